// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the synchronous-sampled serial receiver.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_rx_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  // A one-bit word still needs a one-bit counter so the vectors stay legal.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_rx_if.sv
// Consumer-side bundle of the serial receiver: word, status flags and acknowledges.
// master = receiver (drives data/flags), slave = consumer (drives rd_i/clr_i).
interface serial_rx_if #(
  parameter int DATA_W = serial_rx_pkg::DEF_DATA_W
);

  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              overrun_o;
  logic              frame_err_o;
  logic              rd_i;
  logic              clr_i;

  modport master (
    output data_o,
    output valid_o,
    output overrun_o,
    output frame_err_o,
    input  rd_i,
    input  clr_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  overrun_o,
    input  frame_err_o,
    output rd_i,
    output clr_i
  );

endinterface

// File: rtl/serial_rx_sync_ff.sv
// Multi-flop synchronizer for one asynchronous bit; latency DEPTH clk cycles.
// No backpressure; the reset value sets the idle level seen before the first sample.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {DEPTH{RST_VAL}};
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/serial_rx.sv
// Serial word receiver: oversamples sclk/sdi/cs_n in clk, shifts MSB first, posts words.
// Word visible SYNC_STAGES+1 clk edges after the sclk rise; no stall, overrun flagged instead.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk_i,
  input  logic          sdi_i,
  input  logic          cs_n_i,
  serial_rx_if.master   bus
);

  localparam int              CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic sclk_s;
  logic sdi_s;
  logic cs_n_s;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk),
    .rst (rst),
    .d   (sclk_i),
    .q   (sclk_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk (clk),
    .rst (rst),
    .d   (sdi_i),
    .q   (sdi_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk (clk),
    .rst (rst),
    .d   (cs_n_i),
    .q   (cs_n_s)
  );

  rx_state_e         state_q;
  rx_state_e         state_d;
  logic              sclk_q;
  logic              cs_n_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              overrun_q;
  logic              frame_err_q;
  logic              frame_err_d;

  logic              cs_fall;
  logic              bit_evt;
  logic              bit_act;
  logic              word_done;
  logic              enter_shift;
  logic [DATA_W-1:0] word_nxt;

  assign cs_fall     = cs_n_q & ~cs_n_s;
  assign bit_evt     = sclk_s & ~sclk_q & ~cs_n_s;
  assign bit_act     = bit_evt && (state_q == SHIFT);
  assign word_done   = bit_act && (bit_cnt == LAST);
  assign enter_shift = (state_q == IDLE) && (state_d == SHIFT);
  assign word_nxt    = {shreg[DATA_W-2:0], sdi_s};

  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_n_s) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt != '0);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_s;
      cs_n_q      <= cs_n_s;
      frame_err_q <= frame_err_d;
    end
  end

  // Counter wraps at the word boundary so back-to-back words share one frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (enter_shift) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (bit_act) begin
      bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
      shreg   <= word_nxt;
    end
  end

  // A completing word always wins over a same-cycle read; overrun only if unread.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (word_done) begin
        data_q  <= word_nxt;
        valid_q <= 1'b1;
      end else if (bus.rd_i) begin
        valid_q <= 1'b0;
      end

      if (word_done && valid_q && !bus.rd_i) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.overrun_o   = overrun_q;
  assign bus.frame_err_o = frame_err_q;

endmodule
